video_readback_unpack: RTL and testbench

Display-side counterpart of the per-channel sampling writer. It requests 256-bit pixel words from the DDR read path and buffers them in a small internal FIFO. It then unpacks each word into sixteen RGB565 pixels aligned to the display timing (`vs_in`/`de_in`). The block sits between the DDR read arbiter and the HDMI output timing path, one instance per displayed channel, all in the pixel clock domain.

---
 rtl/video_readback_unpack_if.sv | 22 ++
 rtl/video_readback_unpack.sv | 121 ++++++++++++
 tb/tb_video_readback_unpack.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_readback_unpack_if.sv
// DDR read-path handshake between a display unpacker and the read arbiter.
// The unpacker is the master: it issues requests and sinks returned words.
interface video_readback_unpack_if #(
  parameter int DQ_WIDTH = 32
);
  logic                    rd_req;
  logic [3:0]              rd_trans_id;
  logic                    rd_req_ack;
  logic [DQ_WIDTH*8-1:0]   rd_data_in;
  logic                    rd_data_valid;
  logic                    rd_data_ready;

  modport master (
    output rd_req, rd_trans_id, rd_data_ready,
    input  rd_req_ack, rd_data_in, rd_data_valid
  );

  modport slave (
    input  rd_req, rd_trans_id, rd_data_ready,
    output rd_req_ack, rd_data_in, rd_data_valid
  );
endinterface

// File: rtl/video_readback_unpack.sv
// Prefetches 256-bit pixel words into a small buffer and unpacks them into
// RGB565 pixels following de_in; a vs_in rising edge restarts the frame.
module video_readback_unpack #(
  parameter int          DQ_WIDTH     = 32,
  parameter int          VIDEO_WIDTH  = 1280,
  parameter int          VIDEO_HEIGHT = 720,
  parameter logic [3:0]  IMAGE_TAG    = 4'd1,
  parameter int          BUF_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vs_in,
  input  logic                         de_in,
  video_readback_unpack_if.master      rd_bus,
  output logic [15:0]                  rgb565_out,
  output logic                         de_out,
  output logic                         vs_out,
  output logic                         underflow,
  output logic                         frame_done
);
  localparam int WORD_W = DQ_WIDTH * 8;
  localparam int WPF    = VIDEO_WIDTH / 16 * VIDEO_HEIGHT;
  localparam int CNT_W  = $clog2(WPF) + 1;
  localparam int AW     = $clog2(BUF_DEPTH);
  localparam int LW     = AW + 1;
  localparam logic [CNT_W-1:0] WPF_C   = CNT_W'(WPF);
  localparam logic [LW-1:0]    DEPTH_L = LW'(BUF_DEPTH);
  localparam logic [LW:0]      DEPTH_S = (LW+1)'(BUF_DEPTH);

  logic [WORD_W-1:0] r_mem [BUF_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [LW-1:0]     r_level, r_outst;
  logic [CNT_W-1:0]  r_req_cnt, r_cons_cnt;
  logic [3:0]        r_pix;
  logic              r_vs_d, r_rd_req;

  logic              w_vs_rise, w_empty, w_push, w_pop, w_ack, w_req_cond;
  logic [LW:0]       w_inflight;
  logic [WORD_W-1:0] w_head;

  assign w_vs_rise  = vs_in & ~r_vs_d;
  assign w_empty    = (r_level == '0);
  assign w_pop      = de_in & ~w_empty & (r_pix == 4'hF) & ~w_vs_rise;
  // A pop frees a slot in the same cycle, so a full buffer still accepts then.
  assign rd_bus.rd_data_ready = (r_level < DEPTH_L) | w_pop;
  // Words with nothing outstanding predate the last flush and are dropped.
  assign w_push     = rd_bus.rd_data_valid & rd_bus.rd_data_ready &
                      (r_outst != '0) & ~w_vs_rise;
  assign w_ack      = r_rd_req & rd_bus.rd_req_ack;
  assign w_inflight = {1'b0, r_level} + {1'b0, r_outst};
  assign w_req_cond = (w_inflight < DEPTH_S) & (r_req_cnt < WPF_C) & ~r_rd_req;
  assign w_head     = r_mem[r_rptr];

  assign rd_bus.rd_req      = r_rd_req;
  assign rd_bus.rd_trans_id = r_rd_req ? IMAGE_TAG : 4'd0;
  assign vs_out             = r_vs_d;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= rd_bus.rd_data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vs_d     <= 1'b0;
      r_rd_req   <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_outst    <= '0;
      r_req_cnt  <= '0;
      r_cons_cnt <= '0;
      r_pix      <= '0;
      rgb565_out <= '0;
      de_out     <= 1'b0;
      underflow  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      r_vs_d     <= vs_in;
      de_out     <= de_in;
      frame_done <= 1'b0;
      if (w_vs_rise) begin
        r_rd_req   <= 1'b0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_level    <= '0;
        r_outst    <= '0;
        r_req_cnt  <= '0;
        r_cons_cnt <= '0;
        r_pix      <= '0;
        underflow  <= 1'b0;
        rgb565_out <= '0;
      end else begin
        if (w_ack) begin
          r_rd_req  <= 1'b0;
          r_req_cnt <= r_req_cnt + 1'b1;
        end else if (w_req_cond) begin
          r_rd_req  <= 1'b1;
        end
        r_outst <= r_outst + LW'(w_ack) - LW'(w_push);
        r_level <= r_level + LW'(w_push) - LW'(w_pop);
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;

        // pixel output stage: one pixel per de_in cycle from the head word
        if (!de_in) begin
          rgb565_out <= '0;
        end else if (w_empty) begin
          rgb565_out <= '0;
          underflow  <= 1'b1;
        end else begin
          rgb565_out <= w_head[{r_pix, 4'b0000} +: 16];
          r_pix      <= r_pix + 1'b1;
          if (w_pop) begin
            r_cons_cnt <= r_cons_cnt + 1'b1;
            if (r_cons_cnt == WPF_C - 1'b1) frame_done <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_video_readback_unpack.sv
// Directed bench for video_readback_unpack on a reduced 32x4 frame (8 words).
module tb_video_readback_unpack;
  localparam int DQW = 32;
  localparam int VW  = 32;
  localparam int VH  = 4;
  localparam int BD  = 4;
  localparam int NV  = 160;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vs_in = 1'b0;
  logic        de_in = 1'b0;
  logic [15:0] rgb565_out;
  logic        de_out, vs_out, underflow, frame_done;

  video_readback_unpack_if #(.DQ_WIDTH(DQW)) bus ();

  video_readback_unpack #(
    .DQ_WIDTH(DQW), .VIDEO_WIDTH(VW), .VIDEO_HEIGHT(VH),
    .IMAGE_TAG(4'd1), .BUF_DEPTH(BD)
  ) dut (
    .clk(clk), .rst(rst), .vs_in(vs_in), .de_in(de_in), .rd_bus(bus),
    .rgb565_out(rgb565_out), .de_out(de_out), .vs_out(vs_out),
    .underflow(underflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // arbiter: automatic model or manual drive from the test sequence
  bit             auto_arb = 1'b0;
  bit             data_en  = 1'b1;
  int             ack_delay = 0;
  int             wait_cnt  = 0;
  int             k_next    = 0;
  int             ret_q[$];
  logic           a_ack = 1'b0, a_valid = 1'b0;
  logic [255:0]   a_data = '0;
  logic           m_ack = 1'b0, m_valid = 1'b0;
  logic [255:0]   m_data = '0;

  assign bus.rd_req_ack    = auto_arb ? a_ack   : m_ack;
  assign bus.rd_data_valid = auto_arb ? a_valid : m_valid;
  assign bus.rd_data_in    = auto_arb ? a_data  : m_data;

  function automatic logic [15:0] px(input int k, input int p);
    logic [31:0] kk, pp;
    kk = k;
    pp = p;
    return {kk[11:0], pp[3:0]};
  endfunction

  function automatic logic [255:0] mkword(input int k);
    logic [255:0] w;
    w = '0;
    for (int p = 0; p < 16; p++) w[p*16 +: 16] = px(k, p);
    return w;
  endfunction

  always @(negedge clk) begin
    if (!auto_arb) begin
      a_ack = 1'b0;
      a_valid = 1'b0;
      wait_cnt = 0;
    end else begin
      if (data_en && ret_q.size() > 0) begin
        a_valid = 1'b1;
        a_data  = mkword(ret_q.pop_front());
      end else begin
        a_valid = 1'b0;
      end
      if (bus.rd_req) begin
        if (wait_cnt >= ack_delay) begin
          a_ack = 1'b1;
          ret_q.push_back(k_next);
          k_next++;
          wait_cnt = 0;
        end else begin
          a_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        a_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // all sequence tasks start and end at a falling edge
  task automatic vs_pulse();
    vs_in = 1'b1;
    @(negedge clk);
    vs_in = 1'b0;
  endtask

  task automatic handshake();
    int n = 0;
    while (!bus.rd_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", bus.rd_req, 1);
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
  endtask

  task automatic give_word(input logic [255:0] w);
    m_valid = 1'b1;
    m_data  = w;
    @(negedge clk);
    m_valid = 1'b0;
  endtask

  typedef struct {
    logic        de;
    logic [15:0] rgb;
    logic        fd;
  } vec_t;

  vec_t vt [NV];

  initial begin
    int idx, n, base_d;
    idx = 0;
    for (int l = 0; l < VH; l++) begin
      for (int i = 0; i < VW; i++) begin
        n = l * VW + i;
        vt[idx] = '{1'b1, px(n / 16, n % 16), 1'(n == VW * VH - 1)};
        idx++;
      end
      for (int b = 0; b < 8; b++) begin
        vt[idx] = '{1'b0, 16'h0000, 1'b0};
        idx++;
      end
    end

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rd_req", bus.rd_req, 0);
    chk("rst_trans_id", bus.rd_trans_id, 0);
    chk("rst_ready", bus.rd_data_ready, 1);
    chk("rst_rgb", rgb565_out, 0);
    chk("rst_de_out", de_out, 0);
    chk("rst_vs_out", vs_out, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // frame 1: zero-latency always-ack arbiter, exact pixel stream
    vs_pulse();
    chk("vs_out_hi", vs_out, 1);
    chk("req_flushed", bus.rd_req, 0);
    auto_arb = 1'b1;
    @(negedge clk);
    chk("vs_out_lo", vs_out, 0);
    chk("req_after_vs", bus.rd_req, 1);
    chk("trans_id_tag", bus.rd_trans_id, 1);
    repeat (30) @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      de_in = vt[i].de;
      @(posedge clk); #1;
      chk("frame_px", rgb565_out, vt[i].rgb);
      chk("frame_fd", frame_done, vt[i].fd);
      chk("frame_de_out", de_out, vt[i].de);
      chk("frame_uf", underflow, 0);
      @(negedge clk);
    end
    de_in = 1'b1;
    @(posedge clk); #1;
    chk("extra_px", rgb565_out, 0);
    chk("extra_uf", underflow, 1);
    chk("extra_fd", frame_done, 0);
    @(negedge clk);
    de_in = 1'b0;

    // frame 2: data stalled mid-line
    vs_pulse();
    chk("uf_clr_f2", underflow, 0);
    base_d = k_next;
    repeat (30) @(negedge clk);
    data_en = 1'b0;
    for (int i = 0; i < 80; i++) begin
      de_in = 1'b1;
      @(posedge clk); #1;
      if (i < 64) begin
        chk("stall_px", rgb565_out, px(base_d + i / 16, i % 16));
        chk("stall_uf0", underflow, 0);
      end else begin
        chk("stall_black", rgb565_out, 0);
        chk("stall_uf1", underflow, 1);
      end
      @(negedge clk);
    end
    de_in = 1'b0;
    data_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("uf_sticky", underflow, 1);
    auto_arb = 1'b0;

    // frame 3: vs rise with 3 words buffered and 1 outstanding
    vs_pulse();
    chk("uf_clr_f3", underflow, 0);
    for (int i = 0; i < 4; i++) handshake();
    repeat (5) @(negedge clk);
    chk("req_limit", bus.rd_req, 0);
    for (int i = 0; i < 3; i++) give_word(mkword(100 + i));
    vs_pulse();
    give_word(mkword(103));
    de_in = 1'b1;
    @(posedge clk); #1;
    chk("flush_empty_px", rgb565_out, 0);
    chk("flush_empty_uf", underflow, 1);
    @(negedge clk);
    de_in = 1'b0;
    handshake();
    give_word(mkword(104));
    de_in = 1'b1;
    @(posedge clk); #1;
    chk("newframe_px0", rgb565_out, px(104, 0));
    @(negedge clk);
    de_in = 1'b0;

    // frame 4: fill to depth, then simultaneous push and pop
    vs_pulse();
    chk("uf_clr_f4", underflow, 0);
    for (int i = 0; i < 4; i++) begin
      handshake();
      give_word(mkword(200 + i));
    end
    repeat (3) @(negedge clk);
    chk("full_no_req", bus.rd_req, 0);
    chk("full_ready", bus.rd_data_ready, 0);
    for (int p = 0; p < 16; p++) begin
      de_in = 1'b1;
      #1;
      chk("full_ready_pop", bus.rd_data_ready, 1'(p == 15));
      @(posedge clk); #1;
      chk("full_px", rgb565_out, px(200, p));
      @(negedge clk);
    end
    de_in = 1'b0;
    handshake();
    for (int i = 0; i < 64; i++) begin
      de_in = 1'b1;
      m_valid = 1'(i == 15);
      m_data  = mkword(204);
      @(posedge clk); #1;
      chk("pushpop_px", rgb565_out, px(201 + i / 16, i % 16));
      @(negedge clk);
    end
    m_valid = 1'b0;
    de_in = 1'b0;

    // frame 5: slow acknowledge, data held back
    vs_pulse();
    ack_delay = 10;
    data_en = 1'b0;
    base_d = k_next;
    auto_arb = 1'b1;
    n = 0;
    while (!bus.rd_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("slow_req_rise", bus.rd_req, 1);
    for (int i = 0; i < 10; i++) begin
      chk("slow_req_held", bus.rd_req, 1);
      @(negedge clk);
    end
    repeat (80) @(negedge clk);
    chk("slow_req_stop", bus.rd_req, 0);
    chk("slow_acks", ret_q.size(), 4);

    // asynchronous reset mid-operation
    data_en = 1'b1;
    repeat (10) @(negedge clk);
    de_in = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_px", rgb565_out, px(base_d, 0));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_rgb", rgb565_out, 0);
    chk("arst_de_out", de_out, 0);
    chk("arst_vs_out", vs_out, 0);
    chk("arst_uf", underflow, 0);
    chk("arst_fd", frame_done, 0);
    chk("arst_req", bus.rd_req, 0);
    chk("arst_tid", bus.rd_trans_id, 0);
    chk("arst_ready", bus.rd_data_ready, 1);
    de_in = 1'b0;
    auto_arb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
